lcd_refresh_ctrl: RTL

Character-LCD driver stage for the vending-machine display path. It consumes the two 16-character line buffers produced by the button/transaction handler and drives an HD44780-compatible panel over an 8-bit write-only bus. It runs the power-on init sequence, then rewrites the full screen whenever the line buffers change or a refresh is requested. Each frame is written from an atomic snapshot, so the panel never shows a half-updated screen.

---
 rtl/lcd_pkg.sv | 48 ++++
 rtl/lcd_refresh_ctrl_byte_writer.sv | 83 ++++++++
 rtl/lcd_refresh_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the LCD refresh path.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        ADDR1,
        LINE1,
        ADDR2,
        LINE2
    } lcd_state_t;

    typedef enum logic [1:0] {
        BW_IDLE,
        BW_SETUP,
        BW_EN,
        BW_WAIT
    } bw_state_t;

    localparam logic [7:0] LCD_FUNC  = 8'h38;
    localparam logic [7:0] LCD_ON    = 8'h0C;
    localparam logic [7:0] LCD_CLR   = 8'h01;
    localparam logic [7:0] LCD_ENTRY = 8'h06;
    localparam logic [7:0] LCD_ROW0  = 8'h80;
    localparam logic [7:0] LCD_ROW1  = 8'hC0;
    localparam logic [7:0] LCD_SPACE = 8'h20;

    function automatic logic [7:0] init_cmd(input logic [3:0] i);
        case (i[1:0])
            2'd0:    return LCD_FUNC;
            2'd1:    return LCD_ON;
            2'd2:    return LCD_CLR;
            default: return LCD_ENTRY;
        endcase
    endfunction

    // Column 0 lives in the top byte; NUL is shown as a blank.
    function automatic logic [7:0] lcd_char(input logic [127:0] l,
                                            input logic [3:0] col);
        logic [3:0] j;
        logic [7:0] c;
        j = 4'd15 - col;
        c = l[{j, 3'b000} +: 8];
        return (c == 8'h00) ? LCD_SPACE : c;
    endfunction

endpackage

// File: rtl/lcd_refresh_ctrl_byte_writer.sv
// Single-byte panel write: setup cycle, enable pulse, then settle wait.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned EN_CYC   = 60,
    parameter int unsigned WAIT_CYC = 6_250,
    parameter int unsigned CLR_CYC  = 250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs_in,
    input  logic [7:0] byte_in,
    input  logic       long_wait,
    output logic       rs,
    output logic       en,
    output logic [7:0] data,
    output logic       done
);

    bw_state_t   st, st_d;
    logic [31:0] cnt, cnt_d;
    logic        lw;
    logic        take;

    always_comb begin
        st_d  = st;
        cnt_d = cnt;
        take  = 1'b0;
        done  = 1'b0;
        unique case (st)
            BW_IDLE: ;
            BW_SETUP: begin
                st_d  = BW_EN;
                cnt_d = EN_CYC - 32'd1;
            end
            BW_EN: begin
                if (cnt == 32'd0) begin
                    st_d  = BW_WAIT;
                    cnt_d = (lw ? CLR_CYC : WAIT_CYC) - 32'd1;
                end else begin
                    cnt_d = cnt - 32'd1;
                end
            end
            BW_WAIT: begin
                if (cnt == 32'd0) begin
                    st_d = BW_IDLE;
                    done = 1'b1;
                end else begin
                    cnt_d = cnt - 32'd1;
                end
            end
            default: st_d = BW_IDLE;
        endcase
        // The last wait cycle counts as idle so bytes run back to back.
        if (start && (st == BW_IDLE || done)) begin
            take  = 1'b1;
            st_d  = BW_SETUP;
            cnt_d = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st   <= BW_IDLE;
            cnt  <= 32'd0;
            lw   <= 1'b0;
            rs   <= 1'b0;
            data <= 8'h00;
        end else begin
            st  <= st_d;
            cnt <= cnt_d;
            if (take) begin
                rs   <= rs_in;
                data <= byte_in;
                lw   <= long_wait;
            end
        end
    end

    assign en = (st == BW_EN);

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Character-LCD refresh sequencer: power-on init, then full-screen
// rewrites from an atomic snapshot on input change or refresh request.
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned PWR_CYC  = 5_000_000,
    parameter int unsigned EN_CYC   = 60,
    parameter int unsigned WAIT_CYC = 6_250,
    parameter int unsigned CLR_CYC  = 250_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] line1,
    input  logic [127:0] line2,
    input  logic         refresh,
    output logic         rs,
    output logic         rw,
    output logic         en,
    output logic [7:0]   data,
    output logic         ready,
    output logic         busy
);

    lcd_state_t   st, st_d;
    logic [31:0]  pcnt;
    logic [3:0]   idx, idx_d;
    logic [127:0] snap1, snap2;
    logic         pend;
    logic         cap;
    logic         init_end;
    logic         trig;

    logic         wr_start;
    logic         wr_rs;
    logic [7:0]   wr_byte;
    logic         wr_long;
    logic         wr_done;

    assign trig = pend | (line1 != snap1) | (line2 != snap2);

    always_comb begin
        st_d     = st;
        idx_d    = idx;
        wr_start = 1'b0;
        wr_rs    = 1'b0;
        wr_byte  = 8'h00;
        cap      = 1'b0;
        init_end = 1'b0;
        unique case (st)
            PWR_WAIT: begin
                if (pcnt == PWR_CYC - 32'd1) begin
                    st_d     = INIT;
                    idx_d    = 4'd0;
                    wr_start = 1'b1;
                    wr_byte  = init_cmd(4'd0);
                end
            end
            INIT: begin
                if (wr_done) begin
                    if (idx == 4'd3) begin
                        st_d     = IDLE;
                        init_end = 1'b1;
                    end else begin
                        idx_d    = idx + 4'd1;
                        wr_start = 1'b1;
                        wr_byte  = init_cmd(idx + 4'd1);
                    end
                end
            end
            IDLE: begin
                if (trig) begin
                    st_d     = ADDR1;
                    cap      = 1'b1;
                    wr_start = 1'b1;
                    wr_byte  = LCD_ROW0;
                end
            end
            ADDR1: begin
                if (wr_done) begin
                    st_d     = LINE1;
                    idx_d    = 4'd0;
                    wr_start = 1'b1;
                    wr_rs    = 1'b1;
                    wr_byte  = lcd_char(snap1, 4'd0);
                end
            end
            LINE1: begin
                if (wr_done) begin
                    wr_start = 1'b1;
                    if (idx == 4'd15) begin
                        st_d    = ADDR2;
                        wr_byte = LCD_ROW1;
                    end else begin
                        idx_d   = idx + 4'd1;
                        wr_rs   = 1'b1;
                        wr_byte = lcd_char(snap1, idx + 4'd1);
                    end
                end
            end
            ADDR2: begin
                if (wr_done) begin
                    st_d     = LINE2;
                    idx_d    = 4'd0;
                    wr_start = 1'b1;
                    wr_rs    = 1'b1;
                    wr_byte  = lcd_char(snap2, 4'd0);
                end
            end
            LINE2: begin
                if (wr_done) begin
                    if (idx == 4'd15) begin
                        st_d = IDLE;
                    end else begin
                        idx_d    = idx + 4'd1;
                        wr_start = 1'b1;
                        wr_rs    = 1'b1;
                        wr_byte  = lcd_char(snap2, idx + 4'd1);
                    end
                end
            end
            default: st_d = PWR_WAIT;
        endcase
        wr_long = !wr_rs && (wr_byte == LCD_CLR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st    <= PWR_WAIT;
            pcnt  <= 32'd0;
            idx   <= 4'd0;
            snap1 <= {16{LCD_SPACE}};
            snap2 <= {16{LCD_SPACE}};
            pend  <= 1'b0;
            ready <= 1'b0;
        end else begin
            st  <= st_d;
            idx <= idx_d;
            if (st == PWR_WAIT)
                pcnt <= pcnt + 32'd1;
            if (cap) begin
                snap1 <= line1;
                snap2 <= line2;
            end
            if (init_end)
                ready <= 1'b1;
            // A refresh landing on the capture cycle is kept, not lost.
            if (cap)
                pend <= refresh;
            else if (refresh || init_end)
                pend <= 1'b1;
        end
    end

    assign busy = (st != IDLE);
    assign rw   = 1'b0;

    lcd_byte_writer #(
        .EN_CYC   (EN_CYC),
        .WAIT_CYC (WAIT_CYC),
        .CLR_CYC  (CLR_CYC)
    ) u_wr (
        .clk       (clk),
        .rst       (rst),
        .start     (wr_start),
        .rs_in     (wr_rs),
        .byte_in   (wr_byte),
        .long_wait (wr_long),
        .rs        (rs),
        .en        (en),
        .data      (data),
        .done      (wr_done)
    );

endmodule
